// File: rtl/cache_mem_responder_if.sv
// rtl/cache_mem_responder_if.sv - cache refill/write-back request and return bus
interface cache_mem_responder_if;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [2:0]   wr_size;
  logic [127:0] wr_data;
  logic         wr_rdy;

  modport master (
    output rd_req, rd_type, rd_addr,
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_size, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_type, rd_addr,
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_size, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
  );
endinterface

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - memory-side responder for cache line refill and write-back
// Word-addressed array with independent read and write FSMs and fixed latencies.
module cache_mem_responder #(
  parameter int    ADDR_W    = 10,
  parameter int    RD_LAT    = 2,
  parameter int    WR_LAT    = 2,
  parameter string INIT_FILE = ""
) (
  input logic                  clk,
  input logic                  reset,
  cache_mem_responder_if.slave bus
);
  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA}   r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_COMMIT} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t     r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_buf;
  logic         r_line;
  logic [1:0]   r_off;
  logic [1:0]   r_beat;
  logic         ret_valid_q;
  logic         ret_last_q;
  logic [31:0]  ret_data_q;

  w_state_t          w_state;
  logic [3:0]        w_cnt;
  logic [ADDR_W-1:0] w_idx;
  logic              w_line;
  logic [3:0]        w_strb;
  logic [127:0]      w_data;

  logic         rd_accept;
  logic         wr_accept;
  logic         go_data;
  logic [127:0] rd_snap;
  logic         f_line;
  logic [31:0]  f_data;
  logic         unused_bits;

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] k);
    return line[32*k +: 32];
  endfunction

  // A pending write always blocks reads, and a write request wins a tie.
  assign bus.rd_rdy = !reset && (r_state == R_IDLE) && (w_state == W_IDLE) && !bus.wr_req;
  assign bus.wr_rdy = !reset && (w_state == W_IDLE);
  assign rd_accept  = bus.rd_req && bus.rd_rdy;
  assign wr_accept  = bus.wr_req && bus.wr_rdy;

  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_last  = ret_last_q;
  assign bus.ret_data  = ret_data_q;

  assign unused_bits = ^{bus.wr_size, bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0],
                         bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0]};

  always_comb begin
    rd_snap = '0;
    for (int k = 0; k < 4; k++) begin
      rd_snap[32*k +: 32] = mem[{bus.rd_addr[ADDR_W+1:4], 2'(k)}];
    end
  end

  // First beat comes straight from the array when RD_LAT is 0, else from the snapshot.
  always_comb begin
    if (r_state == R_IDLE) begin
      f_line = (bus.rd_type == TYPE_LINE);
      f_data = f_line ? rd_snap[31:0] : word_of(rd_snap, bus.rd_addr[3:2]);
    end else begin
      f_line = r_line;
      f_data = r_line ? r_buf[31:0] : word_of(r_buf, r_off);
    end
  end

  assign go_data = ((r_state == R_IDLE) && rd_accept && (RD_LAT == 0)) ||
                   ((r_state == R_WAIT) && (r_cnt == 4'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= R_IDLE;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_line      <= 1'b0;
      r_off       <= '0;
      r_beat      <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
    end else begin
      if (go_data) begin
        r_state     <= R_DATA;
        ret_valid_q <= 1'b1;
        ret_data_q  <= f_data;
        ret_last_q  <= !f_line;
        r_beat      <= 2'd1;
      end
      case (r_state)
        R_IDLE: begin
          if (rd_accept) begin
            r_buf  <= rd_snap;
            r_line <= (bus.rd_type == TYPE_LINE);
            r_off  <= bus.rd_addr[3:2];
            if (RD_LAT != 0) begin
              r_state <= R_WAIT;
              r_cnt   <= 4'(RD_LAT - 1);
            end
          end
        end
        R_WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        R_DATA: begin
          if (ret_last_q) begin
            r_state     <= R_IDLE;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_data_q  <= '0;
          end else begin
            ret_data_q <= word_of(r_buf, r_beat);
            ret_last_q <= (r_beat == 2'd3);
            r_beat     <= r_beat + 2'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_idx   <= '0;
      w_line  <= 1'b0;
      w_strb  <= '0;
      w_data  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_accept) begin
            w_idx  <= bus.wr_addr[ADDR_W+1:2];
            w_line <= (bus.wr_type == TYPE_LINE);
            w_strb <= bus.wr_wstrb;
            w_data <= bus.wr_data;
            if (WR_LAT == 0) begin
              w_state <= W_COMMIT;
            end else begin
              w_state <= W_WAIT;
              w_cnt   <= 4'(WR_LAT - 1);
            end
          end
        end
        W_WAIT: begin
          if (w_cnt == 4'd0) w_state <= W_COMMIT;
          else               w_cnt   <= w_cnt - 4'd1;
        end
        W_COMMIT: w_state <= W_IDLE;
        default:  w_state <= W_IDLE;
      endcase
    end
  end

  // Array has no reset: contents survive reset, and reset drops W_COMMIT before any edge.
  always_ff @(posedge clk) begin
    if (w_state == W_COMMIT) begin
      if (w_line) begin
        for (int k = 0; k < 4; k++) begin
          mem[{w_idx[ADDR_W-1:2], 2'(k)}] <= w_data[32*k +: 32];
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - directed and randomized bench for cache_mem_responder
module tb_cache_mem_responder;
  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [31:0] ref_mem [DEPTH];

  cache_mem_responder_if bus();

  cache_mem_responder #(
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [2:0] typ,
                             input logic [3:0] strb, input logic [127:0] data);
    int idx;
    idx = int'((addr >> 2) % DEPTH);
    if (typ == 3'b100) begin
      for (int k = 0; k < 4; k++) ref_mem[(idx / 4) * 4 + k] = data[32*k +: 32];
    end else begin
      for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] typ,
                          input logic [3:0] strb, input logic [127:0] data);
    int n = 0;
    bus.wr_req = 1'b1; bus.wr_addr = addr; bus.wr_type = typ;
    bus.wr_wstrb = strb; bus.wr_data = data; bus.wr_size = 3'($urandom);
    #1;
    while (!bus.wr_rdy && n < 100) begin @(negedge clk); #1; n++; end
    chk("wr_rdy_accept", 32'(bus.wr_rdy), 32'd1);
    chk("rd_rdy_write_wins", 32'(bus.rd_rdy), 32'd0);
    model_write(addr, typ, strb, data);
    for (int i = 1; i <= WR_LAT + 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.wr_req = 1'b0; bus.wr_addr = $urandom; bus.wr_wstrb = 4'($urandom);
        bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      if (i <= WR_LAT + 1) begin
        chk("wr_rdy_busy", 32'(bus.wr_rdy), 32'd0);
        chk("rd_rdy_blocked", 32'(bus.rd_rdy), 32'd0);
      end else begin
        chk("wr_rdy_again", 32'(bus.wr_rdy), 32'd1);
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] typ, input bit mid_write,
                         input logic [31:0] waddr, input logic [127:0] wdata);
    logic [31:0] exp_q[$];
    int n = 0;
    int idx;
    int j;
    bus.rd_req = 1'b1; bus.rd_addr = addr; bus.rd_type = typ;
    #1;
    while (!bus.rd_rdy && n < 100) begin @(negedge clk); #1; n++; end
    chk("rd_rdy_accept", 32'(bus.rd_rdy), 32'd1);
    idx = int'((addr >> 2) % DEPTH);
    if (typ == 3'b100) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(ref_mem[(idx / 4) * 4 + k]);
    end else begin
      exp_q.push_back(ref_mem[idx]);
    end
    @(negedge clk);
    bus.rd_req = 1'b0; bus.rd_addr = $urandom; bus.rd_type = 3'($urandom);
    if (mid_write) begin
      bus.wr_req = 1'b1; bus.wr_addr = waddr; bus.wr_type = 3'b100;
      bus.wr_wstrb = 4'($urandom); bus.wr_data = wdata;
      #1;
      chk("wr_rdy_during_read", 32'(bus.wr_rdy), 32'd1);
      model_write(waddr, 3'b100, 4'h0, wdata);
    end
    for (int i = 1; i <= RD_LAT + exp_q.size(); i++) begin
      if (i > 1) begin @(negedge clk); bus.wr_req = 1'b0; end
      #1;
      chk("rd_rdy_busy", 32'(bus.rd_rdy), 32'd0);
      if (i <= RD_LAT) begin
        chk("ret_valid_wait", 32'(bus.ret_valid), 32'd0);
        chk("ret_data_idle", bus.ret_data, 32'd0);
      end else begin
        j = i - RD_LAT - 1;
        chk("ret_valid_beat", 32'(bus.ret_valid), 32'd1);
        chk("ret_data_beat", bus.ret_data, exp_q[j]);
        chk("ret_last_beat", 32'(bus.ret_last), 32'(j == exp_q.size() - 1));
      end
    end
    @(negedge clk);
    bus.wr_req = 1'b0;
    #1;
    chk("ret_valid_end", 32'(bus.ret_valid), 32'd0);
    chk("ret_data_end", bus.ret_data, 32'd0);
    chk("rd_rdy_end", 32'(bus.rd_rdy), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int op;
    bus.rd_req = 1'b0; bus.rd_type = 3'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_type = 3'b0; bus.wr_addr = '0;
    bus.wr_wstrb = '0; bus.wr_size = '0; bus.wr_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_rd_rdy", 32'(bus.rd_rdy), 32'd0);
    chk("reset_wr_rdy", 32'(bus.wr_rdy), 32'd0);
    chk("reset_ret_valid", 32'(bus.ret_valid), 32'd0);
    chk("reset_ret_last", 32'(bus.ret_last), 32'd0);
    chk("reset_ret_data", bus.ret_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    for (int l = 0; l < DEPTH / 4; l++) begin
      do_write(32'(l * 16), 3'b100, 4'h0, {$urandom, $urandom, $urandom, $urandom});
    end

    do_write(32'h100, 3'b100, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11});
    bus.rd_req = 1'b1; bus.rd_addr = 32'h100; bus.rd_type = 3'b100;
    #1;
    chk("rst_rd_accept", 32'(bus.rd_rdy), 32'd1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    #1;
    chk("rst_beat0_valid", 32'(bus.ret_valid), 32'd1);
    chk("rst_beat0_data", bus.ret_data, 32'h11);
    @(negedge clk);
    #1;
    chk("rst_beat1_data", bus.ret_data, 32'h22);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(bus.ret_valid), 32'd0);
    chk("rst_mid_last", 32'(bus.ret_last), 32'd0);
    chk("rst_mid_data", bus.ret_data, 32'd0);
    chk("rst_mid_rd_rdy", 32'(bus.rd_rdy), 32'd0);
    chk("rst_mid_wr_rdy", 32'(bus.wr_rdy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rel_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    chk("rst_rel_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    do_read(32'h100, 3'b100, 1'b0, '0, '0);
    do_read(32'h100, 3'b100, 1'b0, '0, '0);

    do_write(32'h104, 3'b010, 4'hF, {96'h0, 32'h11223344});
    do_write(32'h104, 3'b010, 4'b0101, {96'h0, 32'hAABBCCDD});
    do_read(32'h104, 3'b010, 1'b0, '0, '0);

    bus.rd_req = 1'b1; bus.rd_addr = 32'h200; bus.rd_type = 3'b100;
    do_write(32'h200, 3'b100, 4'h0, {$urandom, $urandom, $urandom, $urandom});
    do_read(32'h200, 3'b100, 1'b0, '0, '0);

    do_read(32'h100, 3'b100, 1'b1, 32'h100, {$urandom, $urandom, $urandom, $urandom});
    do_read(32'h100, 3'b100, 1'b0, '0, '0);

    do_read(32'h1000, 3'b100, 1'b0, '0, '0);
    do_read(32'h1004, 3'b000, 1'b0, '0, '0);
    do_read(32'h0FFF, 3'b001, 1'b0, '0, '0);

    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 4);
      a  = $urandom;
      case (op)
        0: do_read(a, 3'b100, 1'b0, '0, '0);
        1: do_read(a, 3'($urandom_range(0, 3)), 1'b0, '0, '0);
        2: do_write(a, 3'b100, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
        3: do_write(a, 3'($urandom_range(0, 2)), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
        default: do_read(a, 3'b100, 1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom});
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
